// File: rtl/btn_pkg.sv
// Shared types and constants for the pushbutton debouncer.
package btn_pkg;

  typedef enum logic [1:0] {
    IDLE_LOW,
    ARM_HIGH,
    HELD_HIGH,
    ARM_LOW
  } btn_state_t;

  localparam int unsigned SYNC_STAGES = 2;

endpackage

// File: rtl/sync_2ff.sv
// Generic 1-bit flop-chain synchroniser for an asynchronous input; resets to 0.
module sync_2ff
  import btn_pkg::*;
(
  input  logic clock,
  input  logic reset_n,
  input  logic d,
  output logic q
);

  logic [SYNC_STAGES-1:0] r_sync;

  // Pure flop-to-flop chain so the metastability window is not shortened by logic.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], d};
    end
  end

  assign q = r_sync[SYNC_STAGES-1];

endmodule

// File: rtl/button_debounce.sv
// Pushbutton conditioner: synchronise, qualify stable levels, emit press/release pulses.
// Optional auto-repeat of btn_press while held is enabled by defining BTN_AUTOREPEAT_EN.
module button_debounce
  import btn_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned REPEAT_DELAY    = 25000000,
  parameter int unsigned REPEAT_PERIOD   = 5000000
) (
  input  logic clock,
  input  logic reset_n,
  input  logic button,
  output logic btn_level,
  output logic btn_press,
  output logic btn_release,
  output logic busy
);

  localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  if (DEBOUNCE_CYCLES < 2 || REPEAT_DELAY < 2 || REPEAT_PERIOD < 2) begin : g_param_check
    $error("button_debounce: DEBOUNCE_CYCLES, REPEAT_DELAY and REPEAT_PERIOD must be >= 2");
  end

  logic w_sync;

  sync_2ff u_sync (
    .clock   (clock),
    .reset_n (reset_n),
    .d       (button),
    .q       (w_sync)
  );

  btn_state_t       r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_level;
  logic             r_press;
  logic             r_release;
  logic             r_busy;

`ifdef BTN_AUTOREPEAT_EN
  localparam int unsigned REP_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int unsigned REP_W = $clog2(REP_MAX);
  localparam logic [REP_W-1:0] REP_FIRST = REP_W'(REPEAT_DELAY - 1);
  localparam logic [REP_W-1:0] REP_NEXT  = REP_W'(REPEAT_PERIOD - 1);

  logic [REP_W-1:0] r_rep_cnt;
  logic             r_rep_first;
  logic             w_rep_hit;

  assign w_rep_hit = (r_rep_cnt == (r_rep_first ? REP_FIRST : REP_NEXT));
`endif

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= IDLE_LOW;
      r_cnt     <= '0;
      r_level   <= 1'b0;
      r_press   <= 1'b0;
      r_release <= 1'b0;
      r_busy    <= 1'b0;
`ifdef BTN_AUTOREPEAT_EN
      r_rep_cnt   <= '0;
      r_rep_first <= 1'b1;
`endif
    end else begin
      r_press   <= 1'b0;
      r_release <= 1'b0;
      case (r_state)
        IDLE_LOW: begin
          if (w_sync) begin
            r_state <= ARM_HIGH;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
          end
        end
        ARM_HIGH: begin
          if (!w_sync) begin
            r_state <= IDLE_LOW;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
          end else if (r_cnt == CNT_LAST) begin
            r_state <= HELD_HIGH;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
            r_level <= 1'b1;
            r_press <= 1'b1;
`ifdef BTN_AUTOREPEAT_EN
            r_rep_cnt   <= '0;
            r_rep_first <= 1'b1;
`endif
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        HELD_HIGH: begin
          if (!w_sync) begin
            r_state <= ARM_LOW;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
`ifdef BTN_AUTOREPEAT_EN
          end else if (w_rep_hit) begin
            r_press     <= 1'b1;
            r_rep_cnt   <= '0;
            r_rep_first <= 1'b0;
          end else begin
            r_rep_cnt <= r_rep_cnt + 1'b1;
`endif
          end
        end
        ARM_LOW: begin
          // Repeat counter is deliberately left untouched here: a bounce pauses it.
          if (w_sync) begin
            r_state <= HELD_HIGH;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
          end else if (r_cnt == CNT_LAST) begin
            r_state   <= IDLE_LOW;
            r_cnt     <= '0;
            r_busy    <= 1'b0;
            r_level   <= 1'b0;
            r_release <= 1'b1;
`ifdef BTN_AUTOREPEAT_EN
            r_rep_cnt   <= '0;
            r_rep_first <= 1'b1;
`endif
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: begin
          r_state <= IDLE_LOW;
          r_cnt   <= '0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign btn_level   = r_level;
  assign btn_press   = r_press;
  assign btn_release = r_release;
  assign busy        = r_busy;

endmodule
